// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM and decode encodings,
// default MMIO addresses and the address-decode helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dmem_state_e;

  typedef enum logic [1:0] {
    K_RAM = 2'd0,
    K_LED = 2'd1,
    K_CYC = 2'd2,
    K_ERR = 2'd3
  } dmem_kind_e;

  localparam logic [31:0] DEF_LED_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] DEF_CYC_ADDR = 32'hFFFF_0004;

  localparam int unsigned BYTE_OFS_W = 2;
  localparam int unsigned LAT_CNT_W  = 4;

  // Alignment is checked first, so a misaligned MMIO address is also an error.
  function automatic dmem_kind_e decode(input logic [31:0] addr,
                                        input int unsigned depth_log2,
                                        input logic [31:0] led_addr,
                                        input logic [31:0] cyc_addr);
    if (addr[BYTE_OFS_W-1:0] != '0) return K_ERR;
    if (addr == led_addr) return K_LED;
    if (addr == cyc_addr) return K_CYC;
    if ((addr >> (depth_log2 + BYTE_OFS_W)) != 32'd0) return K_ERR;
    return K_RAM;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a load/store unit and the data-memory responder.
// Handshake: the master raises memreq and holds it (with stable fields) until it
// sees memready; memready is a one-cycle strobe, and readdata/memerr are only
// meaningful in that cycle.
interface dmem_if;
  logic        memreq;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        memready;
  logic        memerr;

  modport master (
    output memreq, memwrite, aluout, writedata,
    input  readdata, memready, memerr
  );

  modport slave (
    input  memreq, memwrite, aluout, writedata,
    output readdata, memready, memerr
  );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous write, asynchronous read, no reset.
module dmem_ram #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: word RAM plus an LED register and a
// free-running cycle counter mapped into the address space.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] LED_ADDR   = DEF_LED_ADDR,
  parameter logic [31:0] CYC_ADDR   = DEF_CYC_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       bus,
  output logic [15:0] led,
  output dmem_state_e dbg_state
);

  localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(LATENCY - 1);

  dmem_state_e           state_q;
  logic [LAT_CNT_W-1:0]  cnt_q;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  dmem_kind_e            kind_q;
  logic [15:0]           led_q;
  logic [31:0]           cyc_q;
  logic                  ready_q;
  logic                  err_q;
  logic [31:0]           rdata_q;

  dmem_kind_e            kind_in, kind_src;
  logic                  we_src;
  logic [DEPTH_LOG2-1:0] idx_in, ram_addr;
  logic [31:0]           ram_rdata, resp_data;
  logic                  enter_resp, ram_we, cyc_clr;

  // With LATENCY=1 the response is built straight from the bus fields in IDLE.
  assign kind_in    = decode(bus.aluout, DEPTH_LOG2, LED_ADDR, CYC_ADDR);
  assign idx_in     = bus.aluout[DEPTH_LOG2+BYTE_OFS_W-1:BYTE_OFS_W];
  assign kind_src   = (state_q == S_IDLE) ? kind_in : kind_q;
  assign we_src     = (state_q == S_IDLE) ? bus.memwrite : we_q;
  assign ram_addr   = (state_q == S_IDLE) ? idx_in : idx_q;
  assign enter_resp = ((state_q == S_IDLE) && bus.memreq && (LATENCY == 1)) ||
                      ((state_q == S_WAIT) && (cnt_q == LAT_CNT_W'(1)));
  assign ram_we     = (state_q == S_RESP) && we_q && (kind_q == K_RAM);
  assign cyc_clr    = (state_q == S_RESP) && we_q && (kind_q == K_CYC);

  // Counter read is registered on the edge entering RESP, hence the +1.
  always_comb begin
    resp_data = '0;
    if (!we_src) begin
      case (kind_src)
        K_RAM:   resp_data = ram_rdata;
        K_LED:   resp_data = {16'h0, led_q};
        K_CYC:   resp_data = cyc_q + 32'd1;
        default: resp_data = '0;
      endcase
    end
  end

  dmem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      kind_q  <= K_RAM;
      led_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= enter_resp;
      err_q   <= enter_resp && (kind_src == K_ERR);
      rdata_q <= enter_resp ? resp_data : '0;
      case (state_q)
        S_IDLE: begin
          if (bus.memreq) begin
            we_q    <= bus.memwrite;
            idx_q   <= idx_in;
            wdata_q <= bus.writedata;
            kind_q  <= kind_in;
            cnt_q   <= CNT_LOAD;
            state_q <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - LAT_CNT_W'(1);
          if (cnt_q == LAT_CNT_W'(1)) state_q <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          if (we_q && (kind_q == K_LED)) led_q <= wdata_q[15:0];
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         cyc_q <= '0;
    else if (cyc_clr) cyc_q <= '0;
    else              cyc_q <= cyc_q + 32'd1;
  end

  assign bus.readdata = rdata_q;
  assign bus.memready = ready_q;
  assign bus.memerr   = err_q;
  assign led          = led_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=1,
// each with an expected-response queue drained by a negedge monitor.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam logic [31:0] LED_A = 32'hFFFF_0000;
  localparam logic [31:0] CYC_A = 32'hFFFF_0004;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  logic        clk;
  logic        rst;
  int          cycle;
  int          checks;
  int          errors;
  logic [15:0] led2, led1;
  dmem_state_e st2, st1;

  logic [32:0] exp_q2[$];
  logic [32:0] exp_q1[$];
  int          cyc_q2[$];
  int          cyc_q1[$];
  vec_t        v1[5];

  dmem_if bus2();
  dmem_if bus1();

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .led(led2), .dbg_state(st2)
  );

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .led(led1), .dbg_state(st1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [32:0] e2, e1;
    int          c2, c1;
    if (rst) begin
      if (bus2.memready) begin
        if (exp_q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut2_unexpected_ready: got memready=1 expected 0 (cycle %0d)", cycle);
        end else begin
          e2 = exp_q2.pop_front();
          c2 = cyc_q2.pop_front();
          chk("dut2_ready_cycle", 32'(cycle), 32'(c2));
          chk("dut2_memerr", {31'b0, bus2.memerr}, {31'b0, e2[32]});
          chk("dut2_readdata", bus2.readdata, e2[31:0]);
        end
      end else begin
        chk("dut2_idle_readdata", bus2.readdata, 32'h0);
        chk("dut2_idle_memerr", {31'b0, bus2.memerr}, 32'h0);
      end
      if (bus1.memready) begin
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1_unexpected_ready: got memready=1 expected 0 (cycle %0d)", cycle);
        end else begin
          e1 = exp_q1.pop_front();
          c1 = cyc_q1.pop_front();
          chk("dut1_ready_cycle", 32'(cycle), 32'(c1));
          chk("dut1_memerr", {31'b0, bus1.memerr}, {31'b0, e1[32]});
          chk("dut1_readdata", bus1.readdata, e1[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge while dut2 is idle; returns at the negedge of the IDLE
  // cycle that follows the response.
  task automatic do_req2(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rd);
    bit seen;
    seen = 1'b0;
    bus2.memreq    = 1'b1;
    bus2.memwrite  = we;
    bus2.aluout    = addr;
    bus2.writedata = wd;
    exp_q2.push_back({exp_err, exp_rd});
    cyc_q2.push_back(cycle + 2);
    @(posedge clk);
    #1;
    // Scramble the fields after acceptance; the request must already be latched.
    bus2.memwrite  = ~we;
    bus2.aluout    = $urandom;
    bus2.writedata = $urandom;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus2.memready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL dut2_timeout: got no memready expected one for addr %h", addr);
    end
    bus2.memreq = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus2.memreq = 1'b0; bus2.memwrite = 1'b0; bus2.aluout = '0; bus2.writedata = '0;
    bus1.memreq = 1'b0; bus1.memwrite = 1'b0; bus1.aluout = '0; bus1.writedata = '0;

    v1[0] = '{we: 1'b1, addr: 32'h8,     wd: 32'hA5A5_0001, err: 1'b0, rd: 32'h0};
    v1[1] = '{we: 1'b0, addr: 32'h8,     wd: 32'h0,         err: 1'b0, rd: 32'hA5A5_0001};
    v1[2] = '{we: 1'b1, addr: LED_A,     wd: 32'h7777_55AA, err: 1'b0, rd: 32'h0};
    v1[3] = '{we: 1'b0, addr: LED_A,     wd: 32'h0,         err: 1'b0, rd: 32'h0000_55AA};
    v1[4] = '{we: 1'b0, addr: 32'h13,    wd: 32'h0,         err: 1'b1, rd: 32'h0};

    repeat (3) @(negedge clk);
    chk("reset_memready", {31'b0, bus2.memready}, 32'h0);
    chk("reset_memerr", {31'b0, bus2.memerr}, 32'h0);
    chk("reset_readdata", bus2.readdata, 32'h0);
    chk("reset_led", {16'h0, led2}, 32'h0);
    chk("reset_state", {30'b0, st2}, {30'b0, S_IDLE});
    chk("reset_state_dut1", {30'b0, st1}, {30'b0, S_IDLE});
    rst = 1'b1;
    @(negedge clk);

    // RAM write/read, errors, aliasing and top word
    do_req2(1'b1, 32'h10,  32'hDEAD_BEEF, 1'b0, 32'h0);
    do_req2(1'b0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF);
    do_req2(1'b0, 32'h13,  32'h0,         1'b1, 32'h0);
    do_req2(1'b0, 32'h400, 32'h0,         1'b1, 32'h0);
    do_req2(1'b1, 32'h0,   32'h0000_1111, 1'b0, 32'h0);
    do_req2(1'b1, 32'h400, 32'h0000_0BAD, 1'b1, 32'h0);
    do_req2(1'b0, 32'h0,   32'h0,         1'b0, 32'h0000_1111);
    do_req2(1'b0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF);
    do_req2(1'b1, 32'h3FC, 32'hCAFE_F00D, 1'b0, 32'h0);
    do_req2(1'b0, 32'h3FC, 32'h0,         1'b0, 32'hCAFE_F00D);

    // LED register
    do_req2(1'b1, LED_A, 32'h1234_ABCD, 1'b0, 32'h0);
    chk("led_after_write", {16'h0, led2}, 32'h0000_ABCD);
    do_req2(1'b0, LED_A, 32'h0, 1'b0, 32'h0000_ABCD);
    do_req2(1'b0, LED_A + 32'd2, 32'h0, 1'b1, 32'h0);

    // Cycle counter: clear edge, then accept edge and WAIT->RESP edge = 2 edges
    do_req2(1'b1, CYC_A, 32'h5555_5555, 1'b0, 32'h0);
    do_req2(1'b0, CYC_A, 32'h0, 1'b0, 32'h2);
    do_req2(1'b0, CYC_A + 32'd4, 32'h0, 1'b1, 32'h0);

    // Reset during WAIT of a write abandons it
    do_req2(1'b1, 32'h20, 32'h1111_1111, 1'b0, 32'h0);
    do_req2(1'b0, 32'h20, 32'h0, 1'b0, 32'h1111_1111);
    bus2.memreq = 1'b1; bus2.memwrite = 1'b1; bus2.aluout = 32'h20; bus2.writedata = 32'h2222_2222;
    @(posedge clk);
    #1;
    chk("accepted_state_wait", {30'b0, st2}, {30'b0, S_WAIT});
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_state", {30'b0, st2}, {30'b0, S_IDLE});
    chk("midreset_memready", {31'b0, bus2.memready}, 32'h0);
    bus2.memreq = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("midreset_led", {16'h0, led2}, 32'h0);
    do_req2(1'b0, 32'h20, 32'h0, 1'b0, 32'h1111_1111);
    do_req2(1'b0, LED_A, 32'h0, 1'b0, 32'h0);

    // LATENCY=1 with memreq held high: one response every two cycles
    bus1.memreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bit seen1;
      seen1 = 1'b0;
      bus1.memwrite  = v1[i].we;
      bus1.aluout    = v1[i].addr;
      bus1.writedata = v1[i].wd;
      exp_q1.push_back({v1[i].err, v1[i].rd});
      cyc_q1.push_back((i == 0) ? cycle + 1 : cycle + 2);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (bus1.memready) begin
          seen1 = 1'b1;
          break;
        end
      end
      if (!seen1) begin
        checks++; errors++;
        $display("FAIL dut1_timeout: got no memready expected one for vector %0d", i);
      end
    end
    bus1.memreq = 1'b0;
    repeat (3) @(negedge clk);
    chk("dut1_led", {16'h0, led1}, 32'h0000_55AA);

    chk("dut2_queue_drained", 32'(exp_q2.size()), 32'h0);
    chk("dut1_queue_drained", 32'(exp_q1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000 time units");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8: RAM holds 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter LATENCY, default 2, legal 1..15: cycles from request acceptance to the memready cycle.
REQ-003 Parameter LED_ADDR, default 32'hFFFF_0000: MMIO LED register byte address.
REQ-004 Parameter CYC_ADDR, default 32'hFFFF_0004: MMIO cycle-counter byte address.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 memreq  input  1  requester asserts and holds high until memready.
REQ-008 memwrite  input  1  1 = write, 0 = read; qualified by memreq.
REQ-009 aluout  input  32  byte address of the request.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  read data; valid only while memready=1.
REQ-012 memready  output  1  one-cycle completion strobe.
REQ-013 memerr  output  1  error flag; valid only while memready=1.
REQ-014 led  output  16  LED register contents.

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 IDLE: memreq=1 at a rising edge latches memwrite, aluout and writedata, loads the down-counter with LATENCY-1, and goes to WAIT; if LATENCY=1, it goes directly to RESP.
REQ-017 WAIT: the counter decrements each cycle, and the FSM goes to RESP on the edge where the counter equals 1.
REQ-018 Therefore memready is high exactly LATENCY cycles after the accepting edge's cycle (LATENCY=2: request in cycle 0, memready in cycle 2).
REQ-019 RESP: memready=1 for one cycle, then the next state is IDLE unconditionally.
REQ-020 memreq is ignored in WAIT and RESP; a new request is accepted no earlier than the IDLE cycle after RESP.
REQ-021 Latched inputs are used for decode and execution; input changes after acceptance have no effect.
REQ-022 Decode, error case: aluout[1:0]!=0, or an address outside RAM (aluout >= 4*2^DEPTH_LOG2) and not LED_ADDR/CYC_ADDR, gives memerr=1 and readdata=0 in RESP, with no state change.
REQ-023 RAM read: readdata = word[aluout[DEPTH_LOG2+1:2]] in RESP.
REQ-024 RAM write: the word is written on the edge ending RESP, and readdata=0 during RESP.
REQ-025 LED read returns {16'h0, led}; LED write sets led <= writedata[15:0] on the edge ending RESP.
REQ-026 Cycle counter: free-running, 32-bit, +1 every cycle, wraps 32'hFFFF_FFFF -> 0.
REQ-027 CYC read returns the counter value during the RESP cycle.
REQ-028 CYC write clears the counter to 0 on the edge ending RESP, and this clear overrides that cycle's increment.
REQ-029 Outside RESP: memready=0, memerr=0, readdata=0.

Reset
REQ-030 rst=0 asynchronously forces: state IDLE, counter 0, memready 0, memerr 0, readdata 0, led 16'h0, cycle counter 0.
REQ-031 Reset mid-operation (WAIT or RESP) abandons the request, and a pending write is never committed.
REQ-032 RAM contents are not reset.

Structure
REQ-033 Shared package dmem_pkg holds the FSM state encodings, default LED_ADDR/CYC_ADDR, and the error-decode width constants.
REQ-034 One sub-module, dmem_ram: single-port array with synchronous write and asynchronous read, parameterized by DEPTH_LOG2.

Verification
REQ-035 Reset, then LATENCY=2, write 32'hDEADBEEF to 0x10, then read 0x10 -> memready in cycle 2 of each request, and the read returns DEADBEEF with memerr=0.
REQ-036 Read at 0x13 (misaligned) and at 0x400 (DEPTH_LOG2=8) -> memerr=1 and readdata=0; a subsequent read of 0x10 is unchanged.
REQ-037 Write 32'h1234ABCD to LED_ADDR -> led=16'hABCD after RESP; read LED_ADDR returns 32'h0000ABCD.
REQ-038 Write to CYC_ADDR, then read CYC_ADDR with LATENCY=2 -> readdata equals the number of edges since the clear edge.
REQ-039 Assert rst=0 during WAIT of a write to 0x20 -> memready never pulses, led=0, and word 0x20 keeps its prior value.
REQ-040 LATENCY=1, with memreq held high continuously across several requests -> memready pulses every 2 cycles (request/RESP alternating).
